// File: rtl/i2c_slave.sv
// i2c_slave: write-only I2C slave that holds the NCO configuration.
//
// Bus protocol: START, address byte (SLAVE_ADDR + W), control byte, then an
// optional payload of FREQ_BYTES or DUTY_BYTES bytes, MSB first.
// Control byte: [0] enable, [2:1] wave, [3] target (1 = frequency, 0 = duty),
// [7:4] ignored. A full payload is committed to its output register in a
// single cycle. A partial payload, address mismatch or read request leaves
// the outputs untouched. The slave never drives SDA.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   reset      synchronous active-high reset
//   scl, sda   I2C bus inputs, asynchronous to clk, oversampled
//   enable     NCO enable
//   wave       waveform select
//   frequency  NCO frequency word (8*FREQ_BYTES bits)
//   duty_cycle duty-cycle word (8*DUTY_BYTES bits)
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h6A,
    parameter int         FREQ_BYTES = 8,
    parameter int         DUTY_BYTES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    scl,
    input  logic                    sda,
    output logic                    enable,
    output logic [1:0]              wave,
    output logic [8*FREQ_BYTES-1:0] frequency,
    output logic [8*DUTY_BYTES-1:0] duty_cycle
);

    localparam int FW   = 8 * FREQ_BYTES;
    localparam int DW   = 8 * DUTY_BYTES;
    localparam int MAXB = (FREQ_BYTES > DUTY_BYTES) ? FREQ_BYTES : DUTY_BYTES;
    localparam int CW   = $clog2(MAXB + 1);

    typedef enum logic [2:0] {IDLE, ADDR, CTRL, DATA, IGNORE} state_t;

    state_t        state, state_next;
    logic [2:0]    scl_sr, sda_sr;     // [0],[1] synchronizer, [2] history
    logic [3:0]    bit_cnt, bit_cnt_next;
    logic [CW-1:0] byte_cnt, byte_cnt_next;
    logic [7:0]    shift_reg;
    logic          target_freq;
    logic [FW-1:0] freq_shadow;
    logic [DW-1:0] duty_shadow;

    logic       scl_rise, start_det, stop_det, sda_bit;
    logic       byte_done, ack_slot;
    logic [7:0] new_byte;
    logic       bit_shift, ctrl_load;
    logic       freq_shift, duty_shift, freq_commit, duty_commit;

    // START/STOP require SCL high on both the synchronized and history
    // samples, so an SDA edge racing an SCL edge is never taken for one.
    assign sda_bit   = sda_sr[1];
    assign scl_rise  = scl_sr[1] & ~scl_sr[2];
    assign start_det = scl_sr[1] & scl_sr[2] & ~sda_sr[1] &  sda_sr[2];
    assign stop_det  = scl_sr[1] & scl_sr[2] &  sda_sr[1] & ~sda_sr[2];

    // Byte currently completing: the 8th sampled bit joins the 7 already held.
    assign new_byte  = {shift_reg[6:0], sda_bit};
    assign byte_done = scl_rise && (bit_cnt == 4'd7);
    assign ack_slot  = scl_rise && (bit_cnt == 4'd8);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next    = state;
        bit_cnt_next  = bit_cnt;
        byte_cnt_next = byte_cnt;
        bit_shift     = 1'b0;
        ctrl_load     = 1'b0;
        freq_shift    = 1'b0;
        duty_shift    = 1'b0;
        freq_commit   = 1'b0;
        duty_commit   = 1'b0;
        if (start_det) begin
            state_next    = ADDR;
            bit_cnt_next  = '0;
            byte_cnt_next = '0;
        end else if (stop_det) begin
            state_next    = IDLE;
            bit_cnt_next  = '0;
            byte_cnt_next = '0;
        end else if (scl_rise && (state == ADDR || state == CTRL || state == DATA)) begin
            bit_cnt_next = (bit_cnt == 4'd8) ? 4'd0 : bit_cnt + 4'd1;
            bit_shift    = (bit_cnt != 4'd8);
            unique case (state)
                ADDR: begin
                    if (ack_slot)
                        state_next = (shift_reg[7:1] == SLAVE_ADDR && !shift_reg[0]) ? CTRL : IGNORE;
                end
                CTRL: begin
                    ctrl_load = byte_done;
                    if (ack_slot) begin
                        state_next    = DATA;
                        byte_cnt_next = '0;
                    end
                end
                DATA: begin
                    if (byte_done) begin
                        byte_cnt_next = byte_cnt + 1'b1;
                        if (target_freq) begin
                            freq_shift = 1'b1;
                            if (byte_cnt == CW'(FREQ_BYTES - 1)) begin
                                freq_commit = 1'b1;
                                state_next  = IGNORE;
                            end
                        end else begin
                            duty_shift = 1'b1;
                            if (byte_cnt == CW'(DUTY_BYTES - 1)) begin
                                duty_commit = 1'b1;
                                state_next  = IGNORE;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sr      <= 3'b111;
            sda_sr      <= 3'b111;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            shift_reg   <= '0;
            target_freq <= 1'b0;
            freq_shadow <= '0;
            duty_shadow <= '0;
            enable      <= 1'b0;
            wave        <= 2'b00;
            frequency   <= '0;
            duty_cycle  <= '0;
        end else begin
            scl_sr   <= {scl_sr[1:0], scl};
            sda_sr   <= {sda_sr[1:0], sda};
            bit_cnt  <= bit_cnt_next;
            byte_cnt <= byte_cnt_next;
            if (start_det) begin
                shift_reg   <= '0;
                freq_shadow <= '0;
                duty_shadow <= '0;
            end else if (bit_shift) begin
                shift_reg <= new_byte;
            end
            if (ctrl_load) begin
                enable      <= new_byte[0];
                wave        <= new_byte[2:1];
                target_freq <= new_byte[3];
            end
            if (freq_shift)  freq_shadow <= {freq_shadow[FW-9:0], new_byte};
            if (duty_shift)  duty_shadow <= {duty_shadow[DW-9:0], new_byte};
            if (freq_commit) frequency   <= {freq_shadow[FW-9:0], new_byte};
            if (duty_commit) duty_cycle  <= {duty_shadow[DW-9:0], new_byte};
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: bit-bangs I2C write transactions into i2c_slave and compares
// its outputs with a byte-level model of the register-update rules.
module tb_i2c_slave;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        scl = 1'b1;
    logic        sda = 1'b1;
    logic        enable;
    logic [1:0]  wave;
    logic [63:0] frequency;
    logic [15:0] duty_cycle;

    int total = 0;
    int bad   = 0;

    logic        m_en;
    logic [1:0]  m_wave;
    logic [63:0] m_freq;
    logic [15:0] m_duty;
    logic [7:0]  seg_q[$];

    i2c_slave dut (
        .clk(clk), .reset(reset), .scl(scl), .sda(sda),
        .enable(enable), .wave(wave), .frequency(frequency), .duty_cycle(duty_cycle)
    );

    always #5 clk = ~clk;

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda = 1'b1; wait_clks(4);
        scl = 1'b1; wait_clks(6);
        sda = 1'b0; wait_clks(6);
        scl = 1'b0; wait_clks(4);
    endtask

    task automatic bus_stop();
        sda = 1'b0; wait_clks(4);
        scl = 1'b1; wait_clks(6);
        sda = 1'b1; wait_clks(6);
    endtask

    task automatic send_bit(input logic b);
        sda = b;    wait_clks(4);
        scl = 1'b1; wait_clks(8);
        scl = 1'b0; wait_clks(4);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        send_bit(1'b1);  // ACK slot, bus released
    endtask

    // One START-delimited segment of bytes: address D4 with at least a
    // control byte applies enable/wave; a payload of 8 (frequency) or 2
    // (duty) bytes or more commits the first bytes, anything shorter is lost.
    function automatic void model_apply();
        int n;
        logic [7:0] c;
        if (seg_q.size() >= 2 && seg_q[0] == 8'hD4) begin
            c = seg_q[1];
            m_en   = c[0];
            m_wave = c[2:1];
            n = seg_q.size() - 2;
            if (c[3] && n >= 8) begin
                m_freq = '0;
                for (int i = 0; i < 8; i++) m_freq = (m_freq << 8) | 64'(seg_q[2+i]);
            end else if (!c[3] && n >= 2) begin
                m_duty = {seg_q[2], seg_q[3]};
            end
        end
    endfunction

    task automatic run_txn();
        bus_start();
        foreach (seg_q[i]) send_byte(seg_q[i]);
        bus_stop();
        model_apply();
    endtask

    task automatic test_reset();
        reset = 1'b1; scl = 1'b1; sda = 1'b1;
        wait_clks(3);
        reset = 1'b0;
        wait_clks(3);
        m_en = 0; m_wave = 0; m_freq = 0; m_duty = 0;
        total++;
        if ({enable, wave, frequency, duty_cycle} !== 83'd0) begin
            bad++;
            $display("FAIL reset: got en=%0b wave=%0d freq=%h duty=%h, want all zero",
                     enable, wave, frequency, duty_cycle);
        end
    endtask

    task automatic test_addr_only();
        seg_q = '{8'hD4};
        run_txn();
        total++;
        if ({enable, wave, frequency, duty_cycle} !== 83'd0) begin
            bad++;
            $display("FAIL addr_only: got en=%0b wave=%0d freq=%h duty=%h, want all zero",
                     enable, wave, frequency, duty_cycle);
        end
    endtask

    task automatic test_enable();
        logic [7:0] c = 8'h01;
        bus_start();
        send_byte(8'hD4);
        for (int i = 7; i >= 0; i--) send_bit(c[i]);
        // Control takes effect on the 8th bit, before the ACK slot.
        total++;
        if (enable !== 1'b1) begin
            bad++;
            $display("FAIL enable_early: got en=%0b, want 1", enable);
        end
        send_bit(1'b1);
        bus_stop();
        seg_q = '{8'hD4, 8'h01};
        model_apply();
        total++;
        if ({enable, wave, frequency, duty_cycle} !== {m_en, m_wave, m_freq, m_duty}) begin
            bad++;
            $display("FAIL enable: got en=%0b wave=%0d freq=%h duty=%h, want en=%0b wave=%0d freq=%h duty=%h",
                     enable, wave, frequency, duty_cycle, m_en, m_wave, m_freq, m_duty);
        end
    endtask

    task automatic test_duty();
        seg_q = '{8'hD4, 8'h02, 8'h2A, 8'h10};
        run_txn();
        total++;
        if ({enable, wave, frequency, duty_cycle} !== {m_en, m_wave, m_freq, m_duty}) begin
            bad++;
            $display("FAIL duty: got en=%0b wave=%0d freq=%h duty=%h, want en=%0b wave=%0d freq=%h duty=%h",
                     enable, wave, frequency, duty_cycle, m_en, m_wave, m_freq, m_duty);
        end
        total++;
        if (duty_cycle !== 16'h2A10) begin
            bad++;
            $display("FAIL duty_const: got %h, want 2a10", duty_cycle);
        end
    endtask

    task automatic test_freq();
        seg_q = '{8'hD4, 8'h08, 8'h00, 8'h1A, 8'h23, 8'h33, 8'hFE, 8'h89, 8'h50, 8'h01};
        run_txn();
        total++;
        if ({enable, wave, frequency, duty_cycle} !== {1'b0, 2'b00, 64'h001A2333FE895001, 16'h2A10}) begin
            bad++;
            $display("FAIL freq: got en=%0b wave=%0d freq=%h duty=%h, want en=0 wave=0 freq=001a2333fe895001 duty=2a10",
                     enable, wave, frequency, duty_cycle);
        end
    endtask

    task automatic test_bad_addr();
        seg_q = '{8'hD6, 8'h01};
        run_txn();
        total++;
        if ({enable, wave, frequency, duty_cycle} !== {m_en, m_wave, m_freq, m_duty}) begin
            bad++;
            $display("FAIL bad_addr: got en=%0b wave=%0d freq=%h duty=%h, want en=%0b wave=%0d freq=%h duty=%h",
                     enable, wave, frequency, duty_cycle, m_en, m_wave, m_freq, m_duty);
        end
        seg_q = '{8'hD5, 8'h07, 8'h55, 8'h66};  // read request
        run_txn();
        total++;
        if ({enable, wave, frequency, duty_cycle} !== {m_en, m_wave, m_freq, m_duty}) begin
            bad++;
            $display("FAIL read_req: got en=%0b wave=%0d freq=%h duty=%h, want en=%0b wave=%0d freq=%h duty=%h",
                     enable, wave, frequency, duty_cycle, m_en, m_wave, m_freq, m_duty);
        end
    endtask

    task automatic test_partial();
        seg_q = '{8'hD4, 8'h0D, 8'hAA, 8'hBB, 8'hCC};
        run_txn();
        total++;
        if ({enable, wave, frequency, duty_cycle} !== {m_en, m_wave, m_freq, m_duty}) begin
            bad++;
            $display("FAIL partial: got en=%0b wave=%0d freq=%h duty=%h, want en=%0b wave=%0d freq=%h duty=%h",
                     enable, wave, frequency, duty_cycle, m_en, m_wave, m_freq, m_duty);
        end
    endtask

    task automatic test_back_to_back();
        bus_start();
        seg_q = '{8'hD4, 8'h0B, 8'h11, 8'h22};
        foreach (seg_q[i]) send_byte(seg_q[i]);
        model_apply();
        bus_start();  // repeated START abandons the frequency payload
        seg_q = '{8'hD4, 8'h04, 8'h12, 8'h34, 8'h56};
        foreach (seg_q[i]) send_byte(seg_q[i]);
        bus_stop();
        model_apply();
        total++;
        if ({enable, wave, frequency, duty_cycle} !== {m_en, m_wave, m_freq, m_duty}) begin
            bad++;
            $display("FAIL back_to_back: got en=%0b wave=%0d freq=%h duty=%h, want en=%0b wave=%0d freq=%h duty=%h",
                     enable, wave, frequency, duty_cycle, m_en, m_wave, m_freq, m_duty);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 15; it++) begin
            int len;
            seg_q = {};
            seg_q.push_back(($urandom_range(0, 9) < 8) ? 8'hD4 : 8'($urandom));
            len = $urandom_range(0, 10);
            for (int k = 0; k < len; k++) seg_q.push_back(8'($urandom));
            run_txn();
            total++;
            if ({enable, wave, frequency, duty_cycle} !== {m_en, m_wave, m_freq, m_duty}) begin
                bad++;
                $display("FAIL random[%0d]: got en=%0b wave=%0d freq=%h duty=%h, want en=%0b wave=%0d freq=%h duty=%h",
                         it, enable, wave, frequency, duty_cycle, m_en, m_wave, m_freq, m_duty);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b = 8'hA5;
        bus_start();
        send_byte(8'hD4);
        send_byte(8'h03);
        for (int i = 7; i >= 5; i--) send_bit(b[i]);
        reset = 1'b1; wait_clks(2);
        reset = 1'b0; wait_clks(2);
        m_en = 0; m_wave = 0; m_freq = 0; m_duty = 0;
        total++;
        if ({enable, wave, frequency, duty_cycle} !== 83'd0) begin
            bad++;
            $display("FAIL reset_mid: got en=%0b wave=%0d freq=%h duty=%h, want all zero",
                     enable, wave, frequency, duty_cycle);
        end
        bus_stop();
        seg_q = '{8'hD4, 8'h05};
        run_txn();
        total++;
        if ({enable, wave, frequency, duty_cycle} !== {m_en, m_wave, m_freq, m_duty}) begin
            bad++;
            $display("FAIL after_reset: got en=%0b wave=%0d freq=%h duty=%h, want en=%0b wave=%0d freq=%h duty=%h",
                     enable, wave, frequency, duty_cycle, m_en, m_wave, m_freq, m_duty);
        end
    endtask

    initial begin
        test_reset();
        test_addr_only();
        test_enable();
        test_duty();
        test_freq();
        test_bad_addr();
        test_partial();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- Write-only I2C slave that receives configuration for the waveform generator (NCO) and holds it in registers: enable, waveform select, 64-bit frequency word and 16-bit duty cycle.
- Sits between the external I2C bus and the NCO core.
- All logic runs on the single system clock.
- SCL and SDA are oversampled inputs; the slave never drives the bus (no ACK drive, no read support).

Parameters:
- SLAVE_ADDR, 7'h6A, 7-bit bus address. The first byte 8'hD4 is address 0x6A with W.
- FREQ_BYTES, 8, number of frequency payload bytes (frequency width = 8*FREQ_BYTES).
- DUTY_BYTES, 2, number of duty payload bytes (duty width = 8*DUTY_BYTES).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- scl  input  1  I2C clock from master, asynchronous to clk.
- sda  input  1  I2C data from master, asynchronous to clk. The slave never drives it.
- enable  output  1  NCO enable.
- wave  output  2  waveform select.
- frequency  output  64  NCO frequency word.
- duty_cycle  output  16  duty-cycle word.

Behaviour:
- Reset (synchronous, active-high): enable=0, wave=2'b00, frequency=0, duty_cycle=0. FSM goes to IDLE; shadow registers and counters are cleared. Reset mid-transfer aborts the transfer.
- Input conditioning:
  - scl and sda each pass through a 2-flop synchronizer plus one history flop.
  - Edges are detected on the synchronized signals.
  - Bus requirement: SCL high and low phases ≥4 clk cycles each; SDA stable ≥2 clk cycles around SCL rising edges.
- START: sync SDA falls while sync SCL is high. Valid from any state, including repeated START. Clears the bit and byte counters; next state is ADDR.
- STOP: sync SDA rises while sync SCL is high. Next state is IDLE; uncommitted shadow data is discarded.
- Bit sampling: data bits are sampled on each sync SCL rising edge, MSB first. The 9th SCL pulse of each byte is the ACK slot; its SDA value is ignored and the slave does not drive SDA.
- FSM states: IDLE, ADDR, CTRL, DATA, IGNORE. Each byte state has an internal 0..8 bit counter; count 8 is the ACK slot.
  - ADDR, after 8 bits:
    - byte[7:1]==SLAVE_ADDR and byte[0]==0 → CTRL after the ACK slot.
    - Otherwise (address mismatch or read request) → IGNORE until STOP or START.
  - CTRL, after 8 bits, with ctrl = the received byte:
    - enable ← ctrl[0], wave ← ctrl[2:1], both updated within 1 clk of the 8th bit's sampling.
    - Target select ← ctrl[3]: 1 = frequency, 0 = duty.
    - ctrl[7:4] are ignored.
    - Next state DATA.
  - DATA:
    - Each byte shifts into a target-specific shadow register, MSB first; the byte counter increments.
    - When byte count reaches FREQ_BYTES (frequency target) or DUTY_BYTES (duty target), the shadow is copied to the output register in one clk (atomic update); next state IGNORE.
    - Partial payload followed by STOP: output unchanged.
  - IGNORE: discards all bits until STOP or START.
- Outputs change only at reset, control-byte completion or payload commit. They hold their values otherwise, including across transactions and STOP.
- Simultaneous START/STOP detect with a bit sample is impossible by construction (SCL high, SDA edge); START/STOP take priority over data sampling.

Test Plan:
- Reset then idle bus (scl=sda=1) → enable=0, wave=0, frequency=0, duty_cycle=0.
- START, 8'hD4, ACK, STOP → all outputs unchanged (0); FSM back in IDLE.
- START, 8'hD4, 8'h01, STOP → enable=1, wave=00; frequency and duty unchanged.
- START, 8'hD4, 8'h02, 8'h2A, 8'h10, STOP → enable=0, wave=01, duty_cycle=16'h2A10.
- START, 8'hD4, 8'h08, 8'h00, 8'h1A, 8'h23, 8'h33, 8'hFE, 8'h89, 8'h50, 8'h01, STOP → enable=0, wave=00, frequency=64'h001A2333FE895001, duty_cycle stays 16'h2A10.
- Negative cases:
  - START, 8'hD6 (address mismatch), 8'h01, STOP → no output change.
  - START, 8'hD4, 8'h08, three payload bytes, STOP → frequency unchanged.
  - reset asserted mid-byte → all outputs return to 0.
